// File: rtl/jtag_tap_sync.sv
// Oversampled IEEE 1149.1 TAP controller: JTAG pins are synchronized into clk_i and
// TCK edges act as clock enables for the TAP FSM, IR, IDCODE/BYPASS/USER data registers.
module jtag_tap_sync #(
   parameter logic [31:0] IdCode     = 32'h1E20_0DB3,
   parameter int unsigned IrWidth    = 5,
   parameter int unsigned SyncStages = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        jtag_tck,
   input  logic        jtag_tms,
   input  logic        jtag_tdi,
   input  logic        jtag_trst_n,
   output logic        jtag_tdo,
   output logic        jtag_tdo_oe,
   input  logic [31:0] user_capture_i,
   output logic [31:0] user_data_o,
   output logic        user_update_o,
   output logic [3:0]  tap_state_o
);

   typedef enum logic [3:0] {
      TLR    = 4'd0,
      RTI    = 4'd1,
      SEL_DR = 4'd2,
      CAP_DR = 4'd3,
      SH_DR  = 4'd4,
      EX1_DR = 4'd5,
      PAU_DR = 4'd6,
      EX2_DR = 4'd7,
      UPD_DR = 4'd8,
      SEL_IR = 4'd9,
      CAP_IR = 4'd10,
      SH_IR  = 4'd11,
      EX1_IR = 4'd12,
      PAU_IR = 4'd13,
      EX2_IR = 4'd14,
      UPD_IR = 4'd15
   } tap_state_e;

   localparam logic [IrWidth-1:0] IrIdcode = IrWidth'(1);
   localparam logic [IrWidth-1:0] IrUser   = IrWidth'(16);

   // Pin bundle layout {trst_n, tdi, tms, tck}; TRST_N idles high so the TAP is not held in reset.
   localparam logic [3:0] SyncRst = 4'b1000;

   logic [3:0] sync_q [SyncStages];
   logic       tck_s, tms_s, tdi_s, trst_s;
   logic       tck_prev_q;
   logic       tck_rise, tck_fall;

   tap_state_e state_q, state_d;

   logic [IrWidth-1:0] ir_q, ir_shift_q;
   logic [31:0]        dr_shift_q;
   logic               sel_idcode, sel_user;

   // ------------------------------------------------------------------
   // Input synchronizer and TCK edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: this array is a few flops, not a RAM, so every stage is reset explicitly.
         for (int i = 0; i < SyncStages; i++) sync_q[i] <= SyncRst;
         tck_prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous stage's pre-edge value.
         sync_q[0] <= {jtag_trst_n, jtag_tdi, jtag_tms, jtag_tck};
         for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
         tck_prev_q <= tck_s;
      end
   end

   assign {trst_s, tdi_s, tms_s, tck_s} = sync_q[SyncStages-1];
   assign tck_rise = tck_s & ~tck_prev_q;
   assign tck_fall = ~tck_s & tck_prev_q;

   // ------------------------------------------------------------------
   // TAP state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= TLR;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (tck_rise) begin
         case (state_q)
            TLR:    state_d = tms_s ? TLR    : RTI;
            RTI:    state_d = tms_s ? SEL_DR : RTI;
            SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_s ? SEL_DR : RTI;
            SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_s ? SEL_DR : RTI;
         endcase
      end
      if (!trst_s) state_d = TLR;
   end

   assign tap_state_o = state_q;

   // ------------------------------------------------------------------
   // Instruction decode; anything other than IDCODE or USER selects BYPASS
   // ------------------------------------------------------------------
   assign sel_idcode = (ir_q == IrIdcode);
   assign sel_user   = (ir_q == IrUser);

   // ------------------------------------------------------------------
   // IR / DR shift paths and USER update, acting on the state being exited
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ir_q          <= IrIdcode;
         ir_shift_q    <= '0;
         dr_shift_q    <= '0;
         user_data_o   <= '0;
         user_update_o <= 1'b0;
      end else begin
         user_update_o <= 1'b0;
         if (!trst_s) begin
            ir_q <= IrIdcode;
         end else if (tck_rise) begin
            case (state_q)
               CAP_IR: ir_shift_q <= IrWidth'(2'b01);
               SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IrWidth-1:1]};
               UPD_IR: ir_q       <= ir_shift_q;
               CAP_DR: begin
                  if (sel_idcode)    dr_shift_q <= IdCode;
                  else if (sel_user) dr_shift_q <= user_capture_i;
                  else               dr_shift_q <= '0;
               end
               SH_DR: begin
                  if (sel_idcode || sel_user) dr_shift_q    <= {tdi_s, dr_shift_q[31:1]};
                  else                        dr_shift_q[0] <= tdi_s;
               end
               UPD_DR: begin
                  if (sel_user) begin
                     user_data_o   <= dr_shift_q;
                     user_update_o <= 1'b1;
                  end
               end
               default: ;
            endcase
            if (state_d == TLR) ir_q <= IrIdcode;
         end
      end
   end

   // ------------------------------------------------------------------
   // TDO launches on the falling TCK edge so the host samples it on the next rise
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         jtag_tdo    <= 1'b0;
         jtag_tdo_oe <= 1'b0;
      end else if (tck_fall) begin
         case (state_q)
            SH_DR: begin
               jtag_tdo    <= dr_shift_q[0];
               jtag_tdo_oe <= 1'b1;
            end
            SH_IR: begin
               jtag_tdo    <= ir_shift_q[0];
               jtag_tdo_oe <= 1'b1;
            end
            default: jtag_tdo_oe <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Self-checking bench for jtag_tap_sync: random IR/DR scans against a transaction-level
// model of the scan chain plus a table-driven model of the 1149.1 state graph.
module tb_jtag_tap_sync;

   localparam logic [31:0] IDCODE = 32'h1E20_0DB3;
   localparam int HALF = 8;
   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_USER   = 5'h10;

   // Successor state for TMS=0 and TMS=1, indexed by the 1149.1 state number.
   localparam logic [3:0] NXT0 [16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                        4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
   localparam logic [3:0] NXT1 [16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                        4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
   logic        jtag_tdo, jtag_tdo_oe;
   logic [31:0] user_capture_i;
   logic [31:0] user_data_o;
   logic        user_update_o;
   logic [3:0]  tap_state_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          upd_cnt  = 0;
   logic [3:0]  m_state;
   logic [4:0]  m_ir;
   logic [31:0] m_user;

   jtag_tap_sync #(
      .IdCode    (IDCODE),
      .IrWidth   (5),
      .SyncStages(2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .jtag_tck      (jtag_tck),
      .jtag_tms      (jtag_tms),
      .jtag_tdi      (jtag_tdi),
      .jtag_trst_n   (jtag_trst_n),
      .jtag_tdo      (jtag_tdo),
      .jtag_tdo_oe   (jtag_tdo_oe),
      .user_capture_i(user_capture_i),
      .user_data_o   (user_data_o),
      .user_update_o (user_update_o),
      .tap_state_o   (tap_state_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) if (rst_ni && user_update_o) upd_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full TCK period; pins change while TCK is low, then rise, then fall.
   task automatic tck_clk(input logic tms, input logic tdi);
      @(negedge clk_i);
      jtag_tms = tms;
      jtag_tdi = tdi;
      @(negedge clk_i);
      jtag_tck = 1'b1;
      repeat (HALF) @(negedge clk_i);
      jtag_tck = 1'b0;
      repeat (HALF) @(negedge clk_i);
      m_state = jtag_trst_n ? (tms ? NXT1[m_state] : NXT0[m_state]) : 4'd0;
      check("tap_state", {28'd0, tap_state_o}, {28'd0, m_state});
   endtask

   // From RTI: shift an IR value, return the captured bits (LSB first), end in RTI.
   task automatic scan_ir(input logic [4:0] v, output logic [4:0] out);
      logic oe_ok;
      oe_ok = 1'b1;
      out   = '0;
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      tck_clk(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         out[i] = jtag_tdo;
         oe_ok &= jtag_tdo_oe;
         tck_clk(logic'(i == 4), v[i]);
      end
      check("ir_oe_shift", {31'd0, oe_ok}, 32'd1);
      check("ir_oe_exit", {31'd0, jtag_tdo_oe}, 32'd0);
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      m_ir = v;
   endtask

   // From RTI: shift len DR bits, return what came out on TDO, end in RTI.
   task automatic scan_dr(input int len, input logic [31:0] din, output logic [31:0] dout);
      logic oe_ok;
      oe_ok = 1'b1;
      dout  = '0;
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      tck_clk(1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         dout[i] = jtag_tdo;
         oe_ok &= jtag_tdo_oe;
         tck_clk(logic'(i == len - 1), din[i]);
      end
      check("dr_oe_shift", {31'd0, oe_ok}, 32'd1);
      check("dr_oe_exit", {31'd0, jtag_tdo_oe}, 32'd0);
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
   endtask

   // IR scan followed by a DR scan, checked against the scan-chain rules.
   task automatic do_txn(input logic [4:0] ir, input logic [31:0] din,
                         input logic [31:0] cap, input int blen);
      logic [4:0]  ir_out;
      logic [31:0] dout, exp, mask;
      int          len, upd0;
      scan_ir(ir, ir_out);
      check("ir_capture", {27'd0, ir_out}, 32'h1);
      user_capture_i = cap;
      upd0 = upd_cnt;
      if (ir == IR_IDCODE) begin
         len = 32;
         exp = IDCODE;
      end else if (ir == IR_USER) begin
         len = 32;
         exp = cap;
      end else begin
         len  = blen;
         mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
         exp  = (din << 1) & mask;
      end
      scan_dr(len, din, dout);
      check("dr_out", dout, exp);
      if (ir == IR_USER) m_user = din;
      check("upd_pulses", upd_cnt - upd0, (ir == IR_USER) ? 32'd1 : 32'd0);
      check("user_data", user_data_o, m_user);
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  ir;
      rst_ni         = 1'b0;
      jtag_tck       = 1'b0;
      jtag_tms       = 1'b0;
      jtag_tdi       = 1'b0;
      jtag_trst_n    = 1'b1;
      user_capture_i = '0;
      m_state        = 4'd0;
      m_ir           = IR_IDCODE;
      m_user         = '0;

      repeat (5) @(negedge clk_i);
      check("rst_state", {28'd0, tap_state_o}, 32'd0);
      check("rst_tdo", {31'd0, jtag_tdo}, 32'd0);
      check("rst_oe", {31'd0, jtag_tdo_oe}, 32'd0);
      check("rst_user_data", user_data_o, 32'd0);
      check("rst_user_upd", {31'd0, user_update_o}, 32'd0);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);

      // IDCODE is selected out of reset without any IR scan
      tck_clk(1'b0, 1'b0);
      scan_dr(32, $urandom, d);
      check("idcode_after_reset", d, IDCODE);

      // Directed: BYPASS with the 1,0,1,1 pattern, then the USER write
      do_txn(5'h1F, 32'h0000_000D, $urandom, 4);
      do_txn(IR_USER, 32'h1234_5678, 32'hCAFE_F00D, 32);
      check("user_value", user_data_o, 32'h1234_5678);

      // Random instructions and data
      for (int n = 0; n < 12; n++) begin
         case ($urandom_range(0, 3))
            0:       ir = IR_IDCODE;
            1:       ir = IR_USER;
            2:       ir = 5'h1F;
            default: ir = 5'($urandom);
         endcase
         do_txn(ir, $urandom, $urandom, $urandom_range(2, 32));
      end

      // Five TMS=1 rises from Shift-IR reach TLR and restore IDCODE
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      tck_clk(1'b0, 1'b0);
      check("shir_oe", {31'd0, jtag_tdo_oe}, 32'd1);
      for (int i = 0; i < 5; i++) tck_clk(1'b1, 1'b1);
      check("tlr_state", {28'd0, tap_state_o}, 32'd0);
      check("tlr_oe", {31'd0, jtag_tdo_oe}, 32'd0);
      tck_clk(1'b0, 1'b0);
      scan_dr(32, $urandom, d);
      check("tlr_idcode", d, IDCODE);

      // Random TMS walk with TDI low so IR can never become USER
      for (int i = 0; i < 40; i++) tck_clk(1'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) tck_clk(1'b1, 1'b0);
      check("walk_tlr_oe", {31'd0, jtag_tdo_oe}, 32'd0);
      tck_clk(1'b0, 1'b0);

      // TRST_N during a USER shift aborts the scan
      do_txn(IR_USER, $urandom | 32'h1, $urandom, 32);
      scan_ir(IR_USER, ir);
      user_capture_i = $urandom;
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      tck_clk(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tck_clk(1'b0, 1'($urandom));
      begin
         int upd0;
         upd0 = upd_cnt;
         jtag_trst_n = 1'b0;
         repeat (6) @(negedge clk_i);
         m_state = 4'd0;
         check("trst_state", {28'd0, tap_state_o}, 32'd0);
         tck_clk(1'b1, 1'b0);
         check("trst_oe", {31'd0, jtag_tdo_oe}, 32'd0);
         check("trst_no_upd", upd_cnt - upd0, 32'd0);
         check("trst_user_data", user_data_o, m_user);
      end
      jtag_trst_n = 1'b1;
      repeat (6) @(negedge clk_i);
      tck_clk(1'b0, 1'b0);
      scan_dr(32, $urandom, d);
      check("trst_idcode", d, IDCODE);

      // rst_ni in Shift-DR with TDO driven high
      scan_ir(IR_USER, ir);
      user_capture_i = 32'hFFFF_FFFF;
      tck_clk(1'b1, 1'b0);
      tck_clk(1'b0, 1'b0);
      tck_clk(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tck_clk(1'b0, 1'b1);
      check("pre_rst_tdo", {31'd0, jtag_tdo}, 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("arst_state", {28'd0, tap_state_o}, 32'd0);
      check("arst_tdo", {31'd0, jtag_tdo}, 32'd0);
      check("arst_oe", {31'd0, jtag_tdo_oe}, 32'd0);
      check("arst_user_data", user_data_o, 32'd0);
      check("arst_user_upd", {31'd0, user_update_o}, 32'd0);
      m_state = 4'd0;
      m_ir    = IR_IDCODE;
      m_user  = '0;
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      tck_clk(1'b0, 1'b0);
      scan_dr(32, $urandom, d);
      check("arst_idcode", d, IDCODE);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
